// File: rtl/riscv64g_iss_csr_pkg.sv
// riscv64g_iss_csr_pkg: shared XLEN, sequencer states, CSR addresses and mstatus field positions.
// XLEN follows the `XLEN macro when the build provides one, else 64.
`ifndef XLEN
`define XLEN 64
`endif
package riscv64g_iss_csr_pkg;
    localparam int XLEN = `XLEN;
    typedef enum logic [2:0] {
        S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_M_STATUS, S_REDIR
    } state_t;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_HI   = 12;
    localparam int MPP_LO   = 11;
    function automatic logic [XLEN-1:0] clr2(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/riscv64g_iss_trap_seq_if.sv
// riscv64g_iss_trap_seq_if: request, CSR write port and redirect signals of the trap sequencer.
interface riscv64g_iss_trap_seq_if;
    import riscv64g_iss_csr_pkg::*;
    logic            TRAP_REQ;
    logic [XLEN-1:0] TRAP_CAUSE;
    logic [XLEN-1:0] TRAP_TVAL;
    logic [XLEN-1:0] TRAP_PC;
    logic            MRET_REQ;
    logic            REQ_ACK;
    logic            BUSY;
    logic            CSR_WE;
    logic [11:0]     CSR_A;
    logic [XLEN-1:0] CSR_WD;
    logic [XLEN-1:0] CSR_RD;
    logic [XLEN-1:0] MTVEC;
    logic [XLEN-1:0] MEPC;
    logic            REDIR_VALID;
    logic [XLEN-1:0] REDIR_PC;
    modport master (
        output TRAP_REQ, TRAP_CAUSE, TRAP_TVAL, TRAP_PC, MRET_REQ, CSR_RD, MTVEC, MEPC,
        input  REQ_ACK, BUSY, CSR_WE, CSR_A, CSR_WD, REDIR_VALID, REDIR_PC
    );
    modport slave (
        input  TRAP_REQ, TRAP_CAUSE, TRAP_TVAL, TRAP_PC, MRET_REQ, CSR_RD, MTVEC, MEPC,
        output REQ_ACK, BUSY, CSR_WE, CSR_A, CSR_WD, REDIR_VALID, REDIR_PC
    );
endinterface

// File: rtl/riscv64g_iss_mstatus_upd.sv
// riscv64g_iss_mstatus_upd: combinational mstatus values for trap entry and MRET.
module riscv64g_iss_mstatus_upd
    import riscv64g_iss_csr_pkg::*;
#(
    parameter logic [1:0] MRET_MPP = 2'b11
) (
    input  logic [XLEN-1:0] old,
    output logic [XLEN-1:0] trap_val,
    output logic [XLEN-1:0] mret_val
);
    always_comb begin
        trap_val                 = old;
        trap_val[MPIE_BIT]       = old[MIE_BIT];
        trap_val[MIE_BIT]        = 1'b0;
        trap_val[MPP_HI:MPP_LO]  = 2'b11;
        mret_val                 = old;
        mret_val[MIE_BIT]        = old[MPIE_BIT];
        mret_val[MPIE_BIT]       = 1'b1;
        mret_val[MPP_HI:MPP_LO]  = MRET_MPP;
    end
endmodule

// File: rtl/riscv64g_iss_trap_seq.sv
// riscv64g_iss_trap_seq: M-mode trap entry / MRET sequencer driving the CSR write port and a PC redirect.
// Define RISCV64G_ISS_VECTORED_TRAP_EN to honour vectored mtvec mode for interrupts.
module riscv64g_iss_trap_seq
    import riscv64g_iss_csr_pkg::*;
#(
    parameter logic [1:0] MRET_MPP = 2'b11
) (
    input logic CLK,
    input logic RST,
    riscv64g_iss_trap_seq_if.slave bus
);
    state_t          state, nxt;
    logic [XLEN-1:0] cause_q, tval_q, pc_q, tgt_q;
    logic [XLEN-1:0] trap_mst, mret_mst, trap_tgt;
    riscv64g_iss_mstatus_upd #(.MRET_MPP(MRET_MPP)) u_upd (
        .old(bus.CSR_RD),
        .trap_val(trap_mst),
        .mret_val(mret_mst)
    );
`ifdef RISCV64G_ISS_VECTORED_TRAP_EN
    // Interrupts in vectored mode land at base + 4*code; exceptions always use the base.
    assign trap_tgt = (bus.MTVEC[1:0] == 2'b01 && cause_q[XLEN-1])
                    ? clr2(bus.MTVEC) + {cause_q[XLEN-3:0], 2'b00} : clr2(bus.MTVEC);
`else
    assign trap_tgt = clr2(bus.MTVEC);
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cause_q <= '0;
            tval_q  <= '0;
            pc_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && bus.TRAP_REQ) begin
                cause_q <= bus.TRAP_CAUSE;
                tval_q  <= bus.TRAP_TVAL;
                pc_q    <= bus.TRAP_PC;
            end
            if (state == S_W_STATUS) tgt_q <= trap_tgt;
            if (state == S_M_STATUS) tgt_q <= clr2(bus.MEPC);
        end
    end
    always_comb begin
        nxt             = state;
        bus.REQ_ACK     = 1'b0;
        bus.CSR_WE      = 1'b0;
        bus.CSR_A       = '0;
        bus.CSR_WD      = '0;
        bus.REDIR_VALID = 1'b0;
        bus.REDIR_PC    = '0;
        case (state)
            S_IDLE: begin
                bus.REQ_ACK = bus.TRAP_REQ | bus.MRET_REQ;
                nxt = bus.TRAP_REQ ? S_W_EPC : bus.MRET_REQ ? S_M_STATUS : S_IDLE;
            end
            S_W_EPC: begin
                bus.CSR_WE = 1'b1;
                bus.CSR_A  = CSR_MEPC;
                bus.CSR_WD = clr2(pc_q);
                nxt        = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                bus.CSR_WE = 1'b1;
                bus.CSR_A  = CSR_MCAUSE;
                bus.CSR_WD = cause_q;
                nxt        = S_W_TVAL;
            end
            S_W_TVAL: begin
                bus.CSR_WE = 1'b1;
                bus.CSR_A  = CSR_MTVAL;
                bus.CSR_WD = tval_q;
                nxt        = S_W_STATUS;
            end
            S_W_STATUS: begin
                bus.CSR_WE = 1'b1;
                bus.CSR_A  = CSR_MSTATUS;
                bus.CSR_WD = trap_mst;
                nxt        = S_REDIR;
            end
            S_M_STATUS: begin
                bus.CSR_WE = 1'b1;
                bus.CSR_A  = CSR_MSTATUS;
                bus.CSR_WD = mret_mst;
                nxt        = S_REDIR;
            end
            S_REDIR: begin
                bus.REDIR_VALID = 1'b1;
                bus.REDIR_PC    = tgt_q;
                nxt             = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end
    assign bus.BUSY = (state != S_IDLE);
endmodule

// File: tb/tb_riscv64g_iss_trap_seq.sv
// tb_riscv64g_iss_trap_seq: directed scenarios against a small mstatus model and a timestamped write/redirect log.
module tb_riscv64g_iss_trap_seq;
    import riscv64g_iss_csr_pkg::*;
    typedef struct {
        int              c;
        logic [11:0]     a;
        logic [XLEN-1:0] d;
    } wr_t;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    logic ld = 1'b0;
    logic [XLEN-1:0] ld_v = '0;
    logic [XLEN-1:0] mst = '0;
    wr_t wq[$];
    wr_t rq[$];
    int aq[$];
    riscv64g_iss_trap_seq_if bus ();
    riscv64g_iss_trap_seq dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    assign bus.CSR_RD = (bus.CSR_A == CSR_MSTATUS) ? mst : '0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ld) mst <= ld_v;
        else if (bus.CSR_WE && bus.CSR_A == CSR_MSTATUS) mst <= bus.CSR_WD;
        if (bus.REQ_ACK) aq.push_back(cyc);
        if (bus.CSR_WE) wq.push_back('{cyc, bus.CSR_A, bus.CSR_WD});
        if (bus.REDIR_VALID) rq.push_back('{cyc, 12'h0, bus.REDIR_PC});
    end
    task automatic clear_logs();
        wq.delete();
        rq.delete();
        aq.delete();
    endtask
    task automatic preload(input logic [XLEN-1:0] v);
        @(posedge CLK) #1;
        ld = 1'b1;
        ld_v = v;
        @(posedge CLK) #1;
        ld = 1'b0;
    endtask
    task automatic req(input logic t, input logic m, input logic [XLEN-1:0] cause,
                       input logic [XLEN-1:0] tval, input logic [XLEN-1:0] pc);
        @(posedge CLK) #1;
        bus.TRAP_REQ = t;
        bus.MRET_REQ = m;
        bus.TRAP_CAUSE = cause;
        bus.TRAP_TVAL = tval;
        bus.TRAP_PC = pc;
        @(posedge CLK) #1;
        bus.TRAP_REQ = 1'b0;
        bus.MRET_REQ = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    task automatic test_reset();
        idle(3);
        RST = 1'b0;
        checks++;
        if ({bus.REQ_ACK, bus.BUSY, bus.CSR_WE, bus.REDIR_VALID} !== 4'b0 || bus.CSR_A !== 12'h0
            || bus.CSR_WD !== '0 || bus.REDIR_PC !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b busy=%b we=%b a=%h wd=%h rv=%b rpc=%h, want all zero",
                     bus.REQ_ACK, bus.BUSY, bus.CSR_WE, bus.CSR_A, bus.CSR_WD, bus.REDIR_VALID, bus.REDIR_PC);
        end
        preload(64'h8);
        clear_logs();
        req(1'b1, 1'b0, 64'd2, 64'hDEAD, 64'h8000_1006);
        @(posedge CLK) #1;
        RST = 1'b1;
        @(posedge CLK) #1;
        checks++;
        if ({bus.BUSY, bus.CSR_WE, bus.REDIR_VALID} !== 3'b0 || bus.CSR_A !== 12'h0 || bus.CSR_WD !== '0) begin
            fails++;
            $display("FAIL reset_abort_outputs: busy=%b we=%b rv=%b a=%h wd=%h, want zero",
                     bus.BUSY, bus.CSR_WE, bus.REDIR_VALID, bus.CSR_A, bus.CSR_WD);
        end
        @(posedge CLK) #1;
        RST = 1'b0;
        idle(8);
        checks++;
        if (wq.size() != 2 || rq.size() != 0 || bus.BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort_log: writes=%0d redirs=%0d busy=%b, want 2 0 0", wq.size(), rq.size(), bus.BUSY);
        end
        foreach (wq[i]) begin
            checks++;
            if (wq[i].a === CSR_MTVAL || wq[i].a === CSR_MSTATUS) begin
                fails++;
                $display("FAIL reset_abort_addr: write to %h after reset, want none to 343/300", wq[i].a);
            end
        end
    endtask
    task automatic test_trap();
        logic [11:0] ea[4] = '{12'h341, 12'h342, 12'h343, 12'h300};
        logic [XLEN-1:0] ed[4] = '{64'h8000_1004, 64'd2, 64'hDEAD, 64'h1880};
        wr_t w;
        int n;
        bus.MTVEC = 64'h8000_0100;
        preload(64'h8);
        clear_logs();
        req(1'b1, 1'b0, 64'd2, 64'hDEAD, 64'h8000_1006);
        idle(8);
        n = (aq.size() > 0) ? aq[0] : -100;
        checks++;
        if (aq.size() != 1 || wq.size() != 4 || rq.size() != 1) begin
            fails++;
            $display("FAIL trap_counts: acks=%0d writes=%0d redirs=%0d, want 1 4 1", aq.size(), wq.size(), rq.size());
        end
        for (int i = 0; i < 4; i++) begin
            w = (i < wq.size()) ? wq[i] : '{-1, 12'h0, '0};
            checks++;
            if (w.c !== n + i + 1 || w.a !== ea[i] || w.d !== ed[i]) begin
                fails++;
                $display("FAIL trap_write%0d: cyc=%0d a=%h wd=%h, want cyc=%0d a=%h wd=%h",
                         i, w.c, w.a, w.d, n + i + 1, ea[i], ed[i]);
            end
        end
        w = (rq.size() > 0) ? rq[0] : '{-1, 12'h0, '0};
        checks++;
        if (w.c !== n + 5 || w.d !== 64'h8000_0100) begin
            fails++;
            $display("FAIL trap_redir: cyc=%0d pc=%h, want cyc=%0d pc=%h", w.c, w.d, n + 5, 64'h8000_0100);
        end
    endtask
    task automatic test_mret();
        wr_t w;
        int n;
        bus.MEPC = 64'h8000_2000;
        preload(64'h1880);
        clear_logs();
        req(1'b0, 1'b1, '0, '0, '0);
        idle(5);
        n = (aq.size() > 0) ? aq[0] : -100;
        checks++;
        if (aq.size() != 1 || wq.size() != 1 || rq.size() != 1) begin
            fails++;
            $display("FAIL mret_counts: acks=%0d writes=%0d redirs=%0d, want 1 1 1", aq.size(), wq.size(), rq.size());
        end
        w = (wq.size() > 0) ? wq[0] : '{-1, 12'h0, '0};
        checks++;
        if (w.c !== n + 1 || w.a !== 12'h300 || w.d !== 64'h1888) begin
            fails++;
            $display("FAIL mret_write: cyc=%0d a=%h wd=%h, want cyc=%0d a=300 wd=1888", w.c, w.a, w.d, n + 1);
        end
        w = (rq.size() > 0) ? rq[0] : '{-1, 12'h0, '0};
        checks++;
        if (w.c !== n + 2 || w.d !== 64'h8000_2000) begin
            fails++;
            $display("FAIL mret_redir: cyc=%0d pc=%h, want cyc=%0d pc=80002000", w.c, w.d, n + 2);
        end
    endtask
    task automatic test_simultaneous();
        wr_t w;
        bus.MTVEC = 64'h2003;
        preload(64'h0);
        clear_logs();
        req(1'b1, 1'b1, 64'd11, 64'h0, 64'h1000);
        bus.TRAP_REQ = 1'b1;
        bus.MRET_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.REQ_ACK !== 1'b0) begin
                fails++;
                $display("FAIL busy_ack%0d: ack=%b, want 0", i, bus.REQ_ACK);
            end
            @(posedge CLK) #1;
        end
        bus.TRAP_REQ = 1'b0;
        bus.MRET_REQ = 1'b0;
        idle(4);
        checks++;
        if (aq.size() != 1 || wq.size() != 4 || rq.size() != 1) begin
            fails++;
            $display("FAIL simul_counts: acks=%0d writes=%0d redirs=%0d, want 1 4 1", aq.size(), wq.size(), rq.size());
        end
        w = (wq.size() > 3) ? wq[3] : '{-1, 12'h0, '0};
        checks++;
        if (w.a !== 12'h300 || w.d !== 64'h1800) begin
            fails++;
            $display("FAIL simul_mstatus: a=%h wd=%h, want a=300 wd=1800", w.a, w.d);
        end
        w = (rq.size() > 0) ? rq[0] : '{-1, 12'h0, '0};
        checks++;
        if (w.d !== 64'h2000) begin
            fails++;
            $display("FAIL simul_redir: pc=%h, want 2000", w.d);
        end
    endtask
    task automatic test_vectored();
        wr_t w;
        logic [XLEN-1:0] exp;
`ifdef RISCV64G_ISS_VECTORED_TRAP_EN
        exp = 64'h8000_011C;
`else
        exp = 64'h8000_0100;
`endif
        bus.MTVEC = 64'h8000_0101;
        clear_logs();
        req(1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h0, 64'h100);
        idle(8);
        w = (rq.size() > 0) ? rq[0] : '{-1, 12'h0, '0};
        checks++;
        if (rq.size() != 1 || w.d !== exp) begin
            fails++;
            $display("FAIL vectored_redir: n=%0d pc=%h, want 1 pc=%h", rq.size(), w.d, exp);
        end
        clear_logs();
        req(1'b1, 1'b0, 64'd7, 64'h0, 64'h100);
        idle(8);
        w = (rq.size() > 0) ? rq[0] : '{-1, 12'h0, '0};
        checks++;
        if (w.d !== 64'h8000_0100) begin
            fails++;
            $display("FAIL vectored_exc_base: pc=%h, want 80000100", w.d);
        end
    endtask
    task automatic test_back_to_back();
        logic [11:0] ea[5] = '{12'h341, 12'h342, 12'h343, 12'h300, 12'h300};
        logic [XLEN-1:0] ed[5] = '{64'h3000, 64'd5, 64'h77, 64'h1880, 64'h1888};
        int ec[5] = '{1, 2, 3, 4, 7};
        wr_t w;
        int n;
        int k;
        bus.MTVEC = 64'h4000;
        bus.MEPC = 64'h5000;
        preload(64'h8);
        clear_logs();
        req(1'b1, 1'b0, 64'd5, 64'h77, 64'h3002);
        k = 0;
        while (bus.REDIR_VALID !== 1'b1 && k < 10) begin
            @(posedge CLK) #1;
            k++;
        end
        checks++;
        if (k >= 10) begin
            fails++;
            $display("FAIL b2b_redir_timeout: no redirect within 10 cycles");
        end
        req(1'b0, 1'b1, '0, '0, '0);
        idle(5);
        n = (aq.size() > 0) ? aq[0] : -100;
        checks++;
        if (aq.size() != 2 || aq[aq.size() - 1] !== n + 6 || wq.size() != 5) begin
            fails++;
            $display("FAIL b2b_accept: acks=%0d writes=%0d, want 2 acks 6 cycles apart and 5 writes", aq.size(), wq.size());
        end
        for (int i = 0; i < 5; i++) begin
            w = (i < wq.size()) ? wq[i] : '{-1, 12'h0, '0};
            checks++;
            if (w.c !== n + ec[i] || w.a !== ea[i] || w.d !== ed[i]) begin
                fails++;
                $display("FAIL b2b_write%0d: cyc=%0d a=%h wd=%h, want cyc=%0d a=%h wd=%h",
                         i, w.c, w.a, w.d, n + ec[i], ea[i], ed[i]);
            end
        end
        w = (rq.size() > 1) ? rq[1] : '{-1, 12'h0, '0};
        checks++;
        if (w.c !== n + 8 || w.d !== 64'h5000) begin
            fails++;
            $display("FAIL b2b_mret_redir: cyc=%0d pc=%h, want cyc=%0d pc=5000", w.c, w.d, n + 8);
        end
    endtask
    initial begin
        bus.TRAP_REQ = 1'b0;
        bus.MRET_REQ = 1'b0;
        bus.TRAP_CAUSE = '0;
        bus.TRAP_TVAL = '0;
        bus.TRAP_PC = '0;
        bus.MTVEC = '0;
        bus.MEPC = '0;
        test_reset();
        test_trap();
        test_mret();
        test_simultaneous();
        test_vectored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/riscv64g_iss_trap_seq.md
Name: riscv64g_iss_trap_seq

Overview:
Machine-mode trap entry/return sequencer for the RV64G ISS, directly upstream of the CSR register file. It accepts a trap or MRET request from the execute stage and drives the CSR file's single write port for the required update sequence. It then issues a one-cycle PC redirect to the fetch stage. While BUSY, the top level muxes this block's CSR_WE/CSR_A/CSR_WD onto the CSR file in place of the execute stage's CSR port.

Parameters:
XLEN, 64, data width; equals `XLEN.
MRET_MPP, 2'b11, value written to mstatus.MPP on MRET (M-only core).

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
TRAP_REQ  in  1  trap request, sampled only in IDLE
TRAP_CAUSE  in  XLEN  mcause value; bit XLEN-1 = interrupt
TRAP_TVAL  in  XLEN  mtval value
TRAP_PC  in  XLEN  PC of trapping instruction
MRET_REQ  in  1  MRET request, sampled only in IDLE
REQ_ACK  out  1  request accepted this cycle
BUSY  out  1  sequencer owns CSR port (state != IDLE)
CSR_WE  out  1  CSR write enable
CSR_A  out  12  CSR address
CSR_WD  out  XLEN  CSR write data
CSR_RD  in  XLEN  combinational read data for CSR_A
MTVEC  in  XLEN  current mtvec
MEPC  in  XLEN  current mepc
REDIR_VALID  out  1  one-cycle PC redirect strobe
REDIR_PC  out  XLEN  redirect target; valid only with REDIR_VALID

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, all captured registers cleared. REQ_ACK, BUSY, CSR_WE, REDIR_VALID are 0; CSR_A=0; CSR_WD=0; REDIR_PC=0.
- Reset mid-sequence aborts immediately. No further CSR writes occur; writes already done are not undone.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIR.
- IDLE, TRAP_REQ=1:
  - REQ_ACK=1 combinationally.
  - TRAP_CAUSE, TRAP_TVAL and TRAP_PC are captured.
  - Next state is W_EPC.
- IDLE, MRET_REQ=1 (TRAP_REQ=0): REQ_ACK=1; next state M_STATUS.
- Both requests asserted together: trap wins and MRET is dropped. The requester must re-present it.
- Requests outside IDLE: ignored, REQ_ACK=0.
- W_EPC: CSR_WE=1, A=12'h341, WD=captured PC with [1:0] cleared.
- W_CAUSE: CSR_WE=1, A=12'h342, WD=captured cause.
- W_TVAL: CSR_WE=1, A=12'h343, WD=captured tval.
- W_STATUS: read-modify-write of mstatus in one cycle. CSR_WE=1, A=12'h300, WD=CSR_RD with:
  - MPIE(bit7) = old MIE(bit3)
  - MIE = 0
  - MPP(12:11) = 2'b11
  - all other bits unchanged
- M_STATUS: CSR_WE=1, A=12'h300, WD=CSR_RD with MIE = old MPIE, MPIE = 1, MPP = MRET_MPP. MEPC is registered as the redirect target.
- REDIR: REDIR_VALID=1 for exactly one cycle; CSR_WE=0; next state IDLE.
  - Trap target: MTVEC sampled in W_STATUS, with [1:0] cleared.
  - MRET target: MEPC value registered in M_STATUS, with [1:0] cleared.
- Latency: trap accepted in cycle N gives writes in N+1..N+4 and REDIR_VALID in N+5. MRET accepted in N gives the write in N+1 and REDIR_VALID in N+2.
- A new request can be accepted in the cycle after REDIR (back-to-back sequences allowed).
- CSR_A and CSR_WD are 0 whenever CSR_WE=0.

Optional Feature:
Macro: RISCV64G_ISS_VECTORED_TRAP_EN.
- Defined: if MTVEC[1:0]==2'b01 and the captured cause has bit XLEN-1 set, the trap target is (MTVEC & ~3) + 4*cause[XLEN-2:0], truncated to XLEN. Exceptions always go to the base.
- Not defined: the MODE field is ignored and the trap target is always MTVEC & ~3.
- MRET behaviour is identical in both builds.

Decomposition:
- Shared package riscv64g_iss_csr_pkg holds:
  - state enum
  - CSR address constants (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343)
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11)
- One natural sub-module: riscv64g_iss_mstatus_upd, purely combinational, computing the trap-entry and MRET mstatus values from the old value.

Test Plan:
- Reset: RST=1 for 2 cycles mid-trap (during W_CAUSE) -> outputs 0, state IDLE, no write to 12'h343 or 12'h300.
- Trap: cause=2, tval=0xDEAD, pc=0x8000_1006, mtvec=0x8000_0100, mstatus=0x8 -> writes mepc=0x8000_1004, mcause=2, mtval=0xDEAD, mstatus=0x1880; REDIR_PC=0x8000_0100 at N+5.
- MRET: mstatus=0x1880, mepc=0x8000_2000 -> mstatus written 0x1888; REDIR_PC=0x8000_2000 at N+2.
- Simultaneous TRAP_REQ=MRET_REQ=1 -> trap sequence only; second request during BUSY gets REQ_ACK=0 and causes no writes.
- Vectored (macro defined): mtvec=0x8000_0101, cause=0x8000_0000_0000_0007 -> REDIR_PC=0x8000_011C; with macro undefined -> 0x8000_0100.
- Back-to-back: trap then MRET presented the cycle after REDIR -> accepted; 4 trap writes, then 1 MRET write, in order.
